// File: rtl/mdu_if.sv
// mdu_if: start/busy/done handshake and operand/result bus for mul_div_unit
// Ports (signals):
//   start  - request, accepted only while the unit is idle
//   op     - RV32M funct3 code
//   a, b   - rs1/rs2 operands, sampled on the accepting edge
//   busy   - operation in flight
//   done   - one-cycle pulse, result valid
//   result - registered result, held until the next completion or reset
// Modports: master drives the request side, slave is the unit itself.
interface mdu_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide, one bit per cycle
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, clears all state
//   bus   - mdu_if slave: start/op/a/b in, busy/done/result out
// Optional feature: define MDU_EARLY_OUT_EN to skip the iterations for
// divide by zero, signed overflow and multiplies with a zero operand.
module mul_div_unit #(parameter int XLEN = 32) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    state_t state, state_nx;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   m;
    logic [2*XLEN-1:0] acc;
    logic              neg, sa_q, div0;
    logic              done_q;
    logic [XLEN-1:0]   result_q;
    logic              sa_en, sb_en, sa, sb, is_div, b_zero, early;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] early_acc, mul_nx, div_nx, prod;
    logic [XLEN:0]     mul_sum, diff;
    logic [XLEN-1:0]   quo, rem, res;
    assign is_div = bus.op[2];
    assign b_zero = bus.b == '0;
`ifdef MDU_EARLY_OUT_EN
    logic ovf;
    assign ovf   = is_div & ~bus.op[0] & (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.b);
    assign early = is_div ? (b_zero | ovf) : (b_zero | (bus.a == '0));
`else
    assign early = 1'b0;
`endif
    always_comb begin
        // Signed operands: MULH/MULHSU take a signed, MULH takes b signed, DIV/REM both
        sa_en   = is_div ? ~bus.op[0] : (bus.op[0] ^ bus.op[1]);
        sb_en   = is_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
        sa      = sa_en & bus.a[XLEN-1];
        sb      = sb_en & bus.b[XLEN-1];
        mag_a   = sa ? -bus.a : bus.a;
        mag_b   = sb ? -bus.b : bus.b;
        // Preloads that let FINISH produce the special-case results directly:
        // divide by zero keeps |a| as remainder, overflow is the normal MIN/1 setup
        early_acc = is_div ? (b_zero ? {mag_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, mag_a}) : '0;
        // Shift-add: high half accumulates the multiplicand, carry shifts in
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
        mul_nx  = {mul_sum, acc[XLEN-1:1]};
        // Restoring divide: acc = {remainder, dividend/quotient}, guard bit flags borrow
        diff    = acc[2*XLEN-1:XLEN-1] - {1'b0, m};
        div_nx  = diff[XLEN] ? {acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], 1'b0}
                             : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        prod    = neg ? -acc : acc;
        quo     = div0 ? '1 : (neg ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
        rem     = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        res     = op_q[2] ? (op_q[1] ? rem : quo)
                          : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (bus.start ? (early ? FINISH : CALC) : IDLE)
                 : (state == CALC) ? (cnt == '0 ? FINISH : CALC)
                 : IDLE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            op_q     <= '0;
            m        <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            sa_q     <= 1'b0;
            div0     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= state == FINISH;
            if (state == IDLE && bus.start) begin
                op_q <= bus.op;
                m    <= is_div ? mag_b : mag_a;
                acc  <= early ? early_acc : {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                neg  <= sa ^ sb;
                sa_q <= sa;
                div0 <= is_div & b_zero;
                cnt  <= CW'(XLEN - 1);
            end else if (state == CALC) begin
                acc <= op_q[2] ? div_nx : mul_nx;
                cnt <= cnt - 1'b1;
            end
            if (state == FINISH) result_q <= res;
        end
    end
    assign bus.busy   = state != IDLE;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit (XLEN=32)
module tb_mul_div_unit;
    localparam int XLEN = 32;
`ifdef MDU_EARLY_OUT_EN
    localparam int EL = 2;
`else
    localparam int EL = 34;
`endif
    logic clk;
    logic reset;
    int checks = 0;
    int failures = 0;
    mdu_if #(.XLEN(XLEN)) bus ();
    mul_div_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h1234_5678;
    endtask
    task automatic wait_done(input string tag, input int n0, output int lat);
        int n = n0;
        int busy_bad = 0;
        while (!bus.done && n < 200) begin
            if (!bus.busy) busy_bad++;
            step();
            n++;
        end
        lat = n;
        check({tag, " busy_during"}, 32'(busy_bad), 32'd0);
        check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    endtask
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        launch(op, a, b);
        wait_done(tag, 1, lat);
        check({tag, " result"}, bus.result, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    endtask
    initial begin
        int lat;
        int pulses;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 3'b000;
        bus.a = '0;
        bus.b = '0;
        step();
        step();
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        reset = 1'b0;
        step();
        run_op("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("MULHSU_pos", 3'b010, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 34);
        run_op("MUL_zero", 3'b000, 32'h0000_1234, 32'd0, 32'd0, EL);
        run_op("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 34);
        run_op("REMU", 3'b111, 32'd100, 32'd7, 32'd2, 34);
        run_op("DIV_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, EL);
        run_op("REM_by0", 3'b110, 32'd5, 32'd0, 32'd5, EL);
        run_op("DIV_neg_by0", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, EL);
        run_op("REM_neg_by0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, EL);
        run_op("DIVU_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, EL);
        run_op("DIV_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EL);
        run_op("REM_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EL);
        // start while busy must be ignored
        launch(3'b100, 32'd100, 32'hFFFF_FFF9);
        for (int i = 0; i < 9; i++) step();
        bus.start = 1'b1;
        bus.op = 3'b000;
        bus.a = 32'd3;
        bus.b = 32'd3;
        step();
        bus.start = 1'b0;
        wait_done("DIV_ignore", 11, lat);
        check("DIV_ignore result", bus.result, 32'hFFFF_FFF2);
        check("DIV_ignore latency", 32'(lat), 32'd34);
        // reset mid-operation
        launch(3'b000, 32'd5, 32'd6);
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        #1;
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        check("midrst result", bus.result, 32'd0);
        step();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.done) pulses++;
        end
        check("midrst no_done", 32'(pulses), 32'd0);
        run_op("DIVU_after_rst", 3'b101, 32'd9, 32'd3, 32'd3, 34);
        // back-to-back: new start in the done cycle
        launch(3'b000, 32'd6, 32'd7);
        wait_done("b2b_first", 1, lat);
        check("b2b_first result", bus.result, 32'd42);
        check("b2b_first latency", 32'(lat), 32'd34);
        launch(3'b101, 32'd1000, 32'd10);
        wait_done("b2b_second", 1, lat);
        check("b2b_second result", bus.result, 32'd100);
        check("b2b_second latency", 32'(lat), 32'd34);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
